// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer for the instruction-fetch stage. Holds the PC
//   register and sequences program load, start and finish. The next fetch
//   address comes from a jump redirect, a branch redirect or a sequential
//   increment, in that priority order. A stall freezes the PC. Also keeps a
//   saturating count of accepted fetches.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   program_loaded    level: program image present (low forces LOAD)
//   program_start     begin execution from READY
//   program_finished  level: leave RUN for HALT
//   stall             freeze PC, state and count this cycle
//   branch_taken/branch_target, jump_valid/jump_target  redirect requests
//   pc_out            registered fetch address
//   pc_plus           pc_out + STEP (combinational, wraps)
//   fetch_valid       pc_out is a live fetch this cycle
//   state_out         FSM state encoding
//   instr_count       accepted fetches since entering RUN, saturating
module pc_sequencer #(
   parameter int unsigned                 ADDR_WIDTH   = 32,
   parameter int unsigned                 STEP         = 4,
   parameter logic [ADDR_WIDTH-1:0]       RESET_VECTOR = '0,
   parameter int unsigned                 COUNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   program_loaded,
   input  logic                   program_start,
   input  logic                   program_finished,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [ADDR_WIDTH-1:0]  branch_target,
   input  logic                   jump_valid,
   input  logic [ADDR_WIDTH-1:0]  jump_target,
   output logic [ADDR_WIDTH-1:0]  pc_out,
   output logic [ADDR_WIDTH-1:0]  pc_plus,
   output logic                   fetch_valid,
   output logic [1:0]             state_out,
   output logic [COUNT_WIDTH-1:0] instr_count
);

   typedef enum logic [1:0] {
      LOAD  = 2'b00,
      READY = 2'b01,
      RUN   = 2'b10,
      HALT  = 2'b11
   } stateT;

   // Clears the low log2(STEP) bits of a redirect target.
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STEP - 1));
   localparam logic [ADDR_WIDTH-1:0] STEP_INC   = ADDR_WIDTH'(STEP);

   stateT                  state, stateNext;
   logic [ADDR_WIDTH-1:0]  pc, pcNext;
   logic [COUNT_WIDTH-1:0] count, countNext;
   logic                   fetchLive;

   assign fetchLive   = (state == RUN) & ~stall & ~program_finished & program_loaded;

   assign pc_out      = pc;
   assign pc_plus     = pc + STEP_INC;
   assign fetch_valid = fetchLive;
   assign state_out   = state;
   assign instr_count = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
         pc    <= RESET_VECTOR;
         count <= '0;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
         count <= countNext;
      end
   end

   always_comb begin
      stateNext = state;
      pcNext    = pc;
      countNext = count;

      if (!program_loaded) begin
         // Unloading overrides everything, including stall and redirects.
         stateNext = LOAD;
         pcNext    = RESET_VECTOR;
      end else begin
         unique case (state)
            LOAD: begin
               pcNext    = RESET_VECTOR;
               stateNext = READY;
            end
            READY: begin
               if (program_start) begin
                  stateNext = RUN;
                  countNext = '0;
               end
            end
            RUN: begin
               // A stall freezes everything; a finish request beats any
               // redirect or increment and leaves the PC where it is.
               if (!stall) begin
                  if (program_finished) begin
                     stateNext = HALT;
                  end else begin
                     if (jump_valid)
                        pcNext = jump_target & ALIGN_MASK;
                     else if (branch_taken)
                        pcNext = branch_target & ALIGN_MASK;
                     else
                        pcNext = pc + STEP_INC;
                     if (count != '1)
                        countNext = count + COUNT_WIDTH'(1);
                  end
               end
            end
            HALT: begin
               stateNext = HALT;
            end
            default: begin
               stateNext = LOAD;
               pcNext    = RESET_VECTOR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam int unsigned        AW = 32;
   localparam int unsigned        ST = 4;
   localparam logic [AW-1:0]      RV = 32'h0;
   localparam longint unsigned    MOD = 64'd1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          loaded = 1'b0, start = 1'b0, fin = 1'b0, stl = 1'b0;
   logic          bt = 1'b0, jv = 1'b0;
   logic [AW-1:0] btgt = '0, jtgt = '0;

   logic [AW-1:0] pcA, pcPlusA, pcB, pcPlusB;
   logic          fvA, fvB;
   logic [1:0]    stA, stB;
   logic [15:0]   cntA;
   logic [3:0]    cntB;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_WIDTH(AW), .STEP(ST), .RESET_VECTOR(RV), .COUNT_WIDTH(16)) dutA (
      .clk(clk), .rst_n(rst_n), .program_loaded(loaded), .program_start(start),
      .program_finished(fin), .stall(stl), .branch_taken(bt), .branch_target(btgt),
      .jump_valid(jv), .jump_target(jtgt), .pc_out(pcA), .pc_plus(pcPlusA),
      .fetch_valid(fvA), .state_out(stA), .instr_count(cntA));

   pc_sequencer #(.ADDR_WIDTH(AW), .STEP(ST), .RESET_VECTOR(RV), .COUNT_WIDTH(4)) dutB (
      .clk(clk), .rst_n(rst_n), .program_loaded(loaded), .program_start(start),
      .program_finished(fin), .stall(stl), .branch_taken(bt), .branch_target(btgt),
      .jump_valid(jv), .jump_target(jtgt), .pc_out(pcB), .pc_plus(pcPlusB),
      .fetch_valid(fvB), .state_out(stB), .instr_count(cntB));

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Reference model: state by name, PC and an unbounded fetch count.
   localparam int S_LOAD = 0, S_READY = 1, S_RUN = 2, S_HALT = 3;
   int              mState;
   longint unsigned mPc;
   longint unsigned mCnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned satTo(input longint unsigned c, input int w);
      longint unsigned lim = (64'd1 << w) - 1;
      return (c > lim) ? lim : c;
   endfunction

   function automatic longint unsigned alignT(input longint unsigned t);
      return (t / ST) * ST;
   endfunction

   function automatic bit expFetch();
      return (mState == S_RUN) && !stl && !fin && loaded;
   endfunction

   task automatic modelReset();
      mState = S_LOAD;
      mPc    = RV;
      mCnt   = 0;
   endtask

   task automatic modelEdge();
      bit f = expFetch();
      if (!loaded) begin
         mState = S_LOAD;
         mPc    = RV;
      end else if (mState == S_LOAD) begin
         mState = S_READY;
      end else if (mState == S_READY && start) begin
         mState = S_RUN;
         mCnt   = 0;
      end else if (mState == S_RUN && !stl && fin) begin
         mState = S_HALT;
      end else if (f) begin
         mPc  = jv ? alignT(jtgt) : bt ? alignT(btgt) : (mPc + ST) % MOD;
         mCnt = mCnt + 1;
      end
   endtask

   task automatic checkPre();
      chk("fetch_valid", {63'd0, fvA}, {63'd0, expFetch()});
      chk("fetch_valid_b", {63'd0, fvB}, {63'd0, expFetch()});
      chk("pc_plus", {32'd0, pcPlusA}, (mPc + ST) % MOD);
   endtask

   task automatic checkPost();
      chk("pc_out", {32'd0, pcA}, mPc);
      chk("pc_out_b", {32'd0, pcB}, mPc);
      chk("state", {62'd0, stA}, mState);
      chk("count16", {48'd0, cntA}, satTo(mCnt, 16));
      chk("count4", {60'd0, cntB}, satTo(mCnt, 4));
   endtask

   // Called just after an edge: settle, check combinational outputs,
   // take the edge, update the model, check registered outputs.
   task automatic cycle();
      #1 checkPre();
      @(posedge clk);
      modelEdge();
      #1 checkPost();
   endtask

   initial begin
      longint unsigned pcHold;
      modelReset();

      // Reset values, before any clock edge.
      #3;
      chk("rst_pc", {32'd0, pcA}, RV);
      chk("rst_state", {62'd0, stA}, 64'd0);
      chk("rst_count", {48'd0, cntA}, 64'd0);
      chk("rst_fv", {63'd0, fvA}, 64'd0);
      chk("rst_pc_plus", {32'd0, pcPlusA}, 64'd4);
      @(negedge clk) rst_n = 1'b1;

      // Load and start, then sequential fetch.
      loaded = 1'b1;
      cycle();
      chk("ready", {62'd0, stA}, 64'd1);
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("run_entry_pc", {32'd0, pcA}, 64'd0);
      chk("run_entry_cnt", {48'd0, cntA}, 64'd0);
      repeat (4) cycle();
      chk("seq_pc", {32'd0, pcA}, 64'h10);

      // Jump beats branch in the same cycle.
      bt = 1'b1; btgt = 32'h42; jv = 1'b1; jtgt = 32'h80;
      cycle();
      chk("jump_pri", {32'd0, pcA}, 64'h80);
      chk("five_fetch", {48'd0, cntA}, 64'd5);
      chk("run_state", {62'd0, stA}, 64'd2);
      jv = 1'b0;
      cycle();
      chk("branch_align", {32'd0, pcA}, 64'h40);

      // Stall with a held branch request.
      stl = 1'b1; btgt = 32'h100;
      repeat (3) begin
         cycle();
         chk("stall_pc", {32'd0, pcA}, 64'h40);
         chk("stall_fv", {63'd0, fvA}, 64'd0);
         chk("stall_cnt", {48'd0, cntA}, 64'd6);
      end
      stl = 1'b0;
      cycle();
      chk("post_stall_branch", {32'd0, pcA}, 64'h100);

      // Wrap at the top of the address space.
      bt = 1'b0; jv = 1'b1; jtgt = 32'hFFFF_FFFF;
      cycle();
      chk("top_pc", {32'd0, pcA}, 64'hFFFF_FFFC);
      chk("top_pc_plus", {32'd0, pcPlusA}, 64'd0);
      jv = 1'b0;
      cycle();
      chk("wrap_pc", {32'd0, pcA}, 64'd0);
      chk("wrap_pc_plus", {32'd0, pcPlusA}, 64'd4);

      repeat (20) cycle();
      chk("sat4", {60'd0, cntB}, 64'd15);

      // Finish beats a simultaneous jump; then unload.
      pcHold = mPc;
      fin = 1'b1; jv = 1'b1; jtgt = 32'h200;
      #1 chk("fin_fv", {63'd0, fvA}, 64'd0);
      cycle();
      chk("halt_state", {62'd0, stA}, 64'd3);
      chk("halt_pc", {32'd0, pcA}, pcHold);
      jv = 1'b0;
      loaded = 1'b0;
      cycle();
      chk("unload_state", {62'd0, stA}, 64'd0);
      chk("unload_pc", {32'd0, pcA}, RV);
      fin = 1'b0;

      // Randomised phase against the model.
      for (int i = 0; i < 400; i++) begin
         loaded = ($urandom_range(0, 19) != 0);
         start  = ($urandom_range(0, 2) == 0);
         fin    = ($urandom_range(0, 24) == 0);
         stl    = fin ? 1'b0 : ($urandom_range(0, 3) == 0);
         bt     = ($urandom_range(0, 3) == 0);
         jv     = ($urandom_range(0, 5) == 0);
         btgt   = $urandom;
         jtgt   = $urandom;
         cycle();
      end

      // Asynchronous reset in the middle of RUN.
      loaded = 1'b0; start = 1'b0; fin = 1'b0; stl = 1'b0; bt = 1'b0; jv = 1'b0;
      cycle();
      loaded = 1'b1;
      cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      chk("pre_reset_run", {62'd0, stA}, 64'd2);
      #2 rst_n = 1'b0;
      #1;
      modelReset();
      chk("async_pc", {32'd0, pcA}, RV);
      chk("async_state", {62'd0, stA}, 64'd0);
      chk("async_count", {48'd0, cntA}, 64'd0);
      chk("async_fv", {63'd0, fvA}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
